// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, the NOP encoding and the fetch FSM
// state type. Imported by every pipeline-stage file.
package cpu_pkg;

    localparam int unsigned ADDR_W    = 12;
    localparam int unsigned DATA_W    = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction ROM bus between the fetch unit (master) and the ROM (slave).
// The ROM is asynchronous-read: rom_data is valid in the same cycle as rom_addr.
//   rom_addr : byte address, word index = rom_addr[ADDR_W-1:2]
//   rom_data : instruction word at rom_addr
interface instr_fetch_unit_if
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W = cpu_pkg::ADDR_W,
    parameter int unsigned DATA_W = cpu_pkg::DATA_W
) ();

    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;

    modport master (output rom_addr, input  rom_data);
    modport slave  (input  rom_addr, output rom_data);

endinterface

// File: rtl/instr_fetch_unit_if_id_reg.sv
// Generic pipeline register (IF/ID here) with flush/load/hold controls.
//   clk, rst_n : clock, async active-low reset
//   load_i     : capture instr_i/pc_i/pc4_i and mark valid
//   flush_i    : insert a bubble (NOP, valid=0); has priority over load_i
//   instr_i, pc_i, pc4_i : data to capture
//   instr_o, pc_o, pc4_o, valid_o : registered contents
// With neither control asserted every field holds.
module if_id_reg
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W = cpu_pkg::ADDR_W,
    parameter int unsigned DATA_W = cpu_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              flush_i,
    input  logic [DATA_W-1:0] instr_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [ADDR_W-1:0] pc4_i,
    output logic [DATA_W-1:0] instr_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] pc4_o,
    output logic              valid_o
);

    logic [DATA_W-1:0] instr_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc4_q;
    logic              valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= DATA_W'(NOP_INSTR);
            pc_q    <= '0;
            pc4_q   <= '0;
            valid_q <= 1'b0;
        end else if (flush_i) begin
            // Bubble: pc/pc4 are left as-is, only the payload is killed.
            instr_q <= DATA_W'(NOP_INSTR);
            valid_q <= 1'b0;
        end else if (load_i) begin
            instr_q <= instr_i;
            pc_q    <= pc_i;
            pc4_q   <= pc4_i;
            valid_q <= 1'b1;
        end
    end

    assign instr_o = instr_q;
    assign pc_o    = pc_q;
    assign pc4_o   = pc4_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// IF stage: program counter, RUN/HALTED fetch FSM, IF/ID register and
// fetched-instruction counter.
//   clk, rst_n          : clock, async active-low reset
//   stall               : freeze PC and IF/ID (ignored under redirect / HALTED)
//   redirect_valid/_pc  : taken branch/jump; flush IF/ID and load new PC
//   halt, resume        : syscall halt / restart pulse (halt wins if both)
//   rom_bus             : ROM bus, rom_addr = pc, rom_data same cycle
//   if_id_*             : IF/ID register contents
//   halted              : FSM in HALTED
//   misalign_err        : sticky, a redirect target had [1:0] != 0
//   fetch_count         : instructions loaded into IF/ID with valid=1
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned       ADDR_W   = cpu_pkg::ADDR_W,
    parameter int unsigned       DATA_W   = cpu_pkg::DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall,
    input  logic                redirect_valid,
    input  logic [ADDR_W-1:0]   redirect_pc,
    input  logic                halt,
    input  logic                resume,
    instr_fetch_unit_if.master  rom_bus,
    output logic [DATA_W-1:0]   if_id_instr,
    output logic [ADDR_W-1:0]   if_id_pc,
    output logic [ADDR_W-1:0]   if_id_pc4,
    output logic                if_id_valid,
    output logic                halted,
    output logic                misalign_err,
    output logic [31:0]         fetch_count
);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pc_plus4;
    logic [31:0]       fetch_count_q, fetch_count_d;
    logic              misalign_q, misalign_d;
    logic              load, flush;

    assign pc_plus4 = pc_q + ADDR_W'(4);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= RUN;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:    if (halt) state_d = HALTED;
            HALTED: if (resume && !halt) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Output / datapath control. The halt edge still advances pc by the usual
    // redirect/stall/normal rule, but the fetched word is discarded (flush).
    always_comb begin
        load          = 1'b0;
        flush         = 1'b0;
        pc_d          = pc_q;
        fetch_count_d = fetch_count_q;
        misalign_d    = misalign_q;
        if (state_q == RUN) begin
            if (redirect_valid) begin
                pc_d  = {redirect_pc[ADDR_W-1:2], 2'b00};
                flush = 1'b1;
                if (redirect_pc[1:0] != 2'b00) misalign_d = 1'b1;
            end else if (!stall) begin
                pc_d = pc_plus4;
                load = !halt;
            end
            if (halt) flush = 1'b1;
            if (load) fetch_count_d = fetch_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            fetch_count_q <= '0;
            misalign_q    <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            fetch_count_q <= fetch_count_d;
            misalign_q    <= misalign_d;
        end
    end

    if_id_reg #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_if_id (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (load),
        .flush_i (flush),
        .instr_i (rom_bus.rom_data),
        .pc_i    (pc_q),
        .pc4_i   (pc_plus4),
        .instr_o (if_id_instr),
        .pc_o    (if_id_pc),
        .pc4_o   (if_id_pc4),
        .valid_o (if_id_valid)
    );

    assign rom_bus.rom_addr = pc_q;
    assign halted           = (state_q == HALTED);
    assign misalign_err     = misalign_q;
    assign fetch_count      = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a behavioural ROM and a queue of
// expected IF/ID contents filled when a fetch is issued.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, redirect_valid, halt, resume;
    logic [11:0] redirect_pc;
    logic [31:0] if_id_instr;
    logic [11:0] if_id_pc, if_id_pc4;
    logic        if_id_valid, halted, misalign_err;
    logic [31:0] fetch_count;

    logic [31:0] rom [1024];

    int n_asserts = 0;
    int n_fail    = 0;

    typedef struct {
        logic [11:0] pc;
        logic [31:0] instr;
    } fetch_t;
    fetch_t sb[$];

    // Reference state
    logic [11:0] m_pc, m_if_pc, m_if_pc4;
    logic [31:0] m_if_instr, m_count;
    logic        m_valid, m_halted, m_mis;

    instr_fetch_unit_if #(.ADDR_W(12), .DATA_W(32)) bus ();
    assign bus.rom_data = rom[bus.rom_addr[11:2]];

    instr_fetch_unit #(
        .ADDR_W   (12),
        .DATA_W   (32),
        .RESET_PC (12'h000)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .resume         (resume),
        .rom_bus        (bus),
        .if_id_instr    (if_id_instr),
        .if_id_pc       (if_id_pc),
        .if_id_pc4      (if_id_pc4),
        .if_id_valid    (if_id_valid),
        .halted         (halted),
        .misalign_err   (misalign_err),
        .fetch_count    (fetch_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 12'h000; m_if_pc = '0; m_if_pc4 = '0; m_if_instr = '0;
        m_count = '0; m_valid = 1'b0; m_halted = 1'b0; m_mis = 1'b0;
        sb.delete();
    endtask

    task automatic check_all(input string ph);
        chk({ph, ":rom_addr"},     32'(bus.rom_addr), 32'(m_pc));
        chk({ph, ":if_id_pc"},     32'(if_id_pc),     32'(m_if_pc));
        chk({ph, ":if_id_pc4"},    32'(if_id_pc4),    32'(m_if_pc4));
        chk({ph, ":if_id_instr"},  if_id_instr,       m_if_instr);
        chk({ph, ":if_id_valid"},  32'(if_id_valid),  32'(m_valid));
        chk({ph, ":halted"},       32'(halted),       32'(m_halted));
        chk({ph, ":misalign_err"}, 32'(misalign_err), 32'(m_mis));
        chk({ph, ":fetch_count"},  fetch_count,       m_count);
    endtask

    // One clock: drive inputs, predict, clock, compare.
    task automatic cyc(input string ph, input logic st, input logic rd,
                       input logic [11:0] rpc, input logic hl, input logic rs);
        fetch_t e;
        stall = st; redirect_valid = rd; redirect_pc = rpc; halt = hl; resume = rs;
        chk({ph, ":rom_addr_pre"}, 32'(bus.rom_addr), 32'(m_pc));
        if (!m_halted) begin
            if (rd) begin
                m_pc = {rpc[11:2], 2'b00};
                m_if_instr = '0;
                m_valid = 1'b0;
                if (rpc[1:0] != 2'b00) m_mis = 1'b1;
            end else if (!st) begin
                if (!hl) begin
                    sb.push_back('{pc: m_pc, instr: rom[m_pc[11:2]]});
                    m_count = m_count + 32'd1;
                end
                m_pc = m_pc + 12'd4;
            end
            if (hl) begin
                m_if_instr = '0;
                m_valid = 1'b0;
            end
        end
        m_halted = hl | (m_halted & ~rs);
        @(posedge clk); #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            m_if_pc = e.pc; m_if_pc4 = e.pc + 12'd4; m_if_instr = e.instr; m_valid = 1'b1;
        end
        check_all(ph);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = 32'hA500_0000 | 32'(i);
        rom[0] = 32'h2008_0001;
        rom[1] = 32'h2009_0002;
        rom[2] = 32'h0109_5020;

        rst_n = 1'b0; stall = 0; redirect_valid = 0; redirect_pc = '0; halt = 0; resume = 0;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        check_all("reset");
        rst_n = 1'b1;

        // Sequential fetch, stall at pc=0x008, then fetch 0x008
        cyc("fetch0", 0, 0, 12'h000, 0, 0);
        cyc("fetch4", 0, 0, 12'h000, 0, 0);
        cyc("stall1", 1, 0, 12'h000, 0, 0);
        cyc("stall2", 1, 0, 12'h000, 0, 0);
        cyc("fetch8", 0, 0, 12'h000, 0, 0);

        // Redirect overrides stall
        cyc("redir",     1, 1, 12'h100, 0, 0);
        cyc("redir_f0",  0, 0, 12'h000, 0, 0);
        cyc("redir_f1",  0, 0, 12'h000, 0, 0);

        // Misaligned redirect, sticky flag
        cyc("misal",     0, 1, 12'h103, 0, 0);
        cyc("misal_f0",  0, 0, 12'h000, 0, 0);
        cyc("misal_f1",  1, 0, 12'h000, 0, 0);
        cyc("misal_f2",  0, 0, 12'h000, 0, 0);

        // Wrap-around at top of ROM
        cyc("wrap_rd",   0, 1, 12'hFF8, 0, 0);
        cyc("wrap_ff8",  0, 0, 12'h000, 0, 0);
        cyc("wrap_ffc",  0, 0, 12'h000, 0, 0);
        cyc("wrap_000",  0, 0, 12'h000, 0, 0);

        // Halt at 0x040; stall/redirect ignored while halted
        cyc("halt_rd",   0, 1, 12'h040, 0, 0);
        cyc("halt_edge", 0, 0, 12'h000, 1, 0);
        for (int i = 0; i < 10; i++)
            cyc("halted", 1'(i % 2), 1'(i == 3 || i == 7), 12'h200, 0, 0);
        cyc("halt_res",  0, 0, 12'h000, 1, 1);
        cyc("resume",    0, 0, 12'h000, 0, 1);
        cyc("res_f044",  0, 0, 12'h000, 0, 0);
        cyc("res_f048",  0, 0, 12'h000, 0, 0);

        // Async reset in the middle of a halt
        cyc("halt2",     0, 0, 12'h000, 1, 0);
        cyc("halt2_h",   0, 0, 12'h000, 0, 0);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc("post_f0",   0, 0, 12'h000, 0, 0);
        cyc("post_f4",   0, 0, 12'h000, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- IF stage of the MIPS pipeline. Holds the program counter and drives the byte address into the asynchronous-read instruction ROM (word index = addr[11:2]).
- Captures the returned 32-bit word into the IF/ID pipeline register.
- Handles stall, branch/jump redirect (flush), halt/resume from syscall, and counts fetched instructions for benchmark statistics.

Parameters:
- ADDR_W, 12, PC/ROM byte-address width (4 KiB, 1024 words)
- DATA_W, 32, instruction width
- RESET_PC, 12'h000, PC value after reset

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  hazard stall from ID; freeze PC and IF/ID
- redirect_valid  in  1  taken branch/jump from EX; flush and load new PC
- redirect_pc  in  ADDR_W  redirect target byte address
- halt  in  1  syscall-halt request
- resume  in  1  single-cycle restart pulse (board button, already synchronised)
- rom_addr  out  ADDR_W  byte address to ROM; combinational, equals pc
- rom_data  in  DATA_W  ROM word, valid same cycle as rom_addr
- if_id_instr  out  DATA_W  registered instruction
- if_id_pc  out  ADDR_W  PC of if_id_instr
- if_id_pc4  out  ADDR_W  if_id_pc + 4, modulo 2^ADDR_W
- if_id_valid  out  1  IF/ID holds a real instruction
- halted  out  1  FSM is in HALTED
- misalign_err  out  1  sticky; a redirect_pc with [1:0] != 0 was received
- fetch_count  out  32  number of instructions loaded into IF/ID with valid=1

Behaviour:
- Reset (async, rst_n=0) values:
  - pc = RESET_PC; state = RUN.
  - if_id_instr = 0 (NOP), if_id_pc = 0, if_id_pc4 = 0, if_id_valid = 0.
  - misalign_err = 0, fetch_count = 0.
  - Deassertion is clocked normally; the first fetch is from RESET_PC on the first edge after release.
- FSM states: RUN and HALTED.
  - RUN -> HALTED on halt=1.
  - HALTED -> RUN on resume=1 when halt=0.
  - halt and resume in the same cycle: halt wins.
- Per rising edge in RUN, in priority order:
  1. redirect_valid=1 (overrides stall):
     - pc <= {redirect_pc[ADDR_W-1:2], 2'b00}.
     - if_id_valid <= 0, if_id_instr <= 0.
     - misalign_err <= 1 if redirect_pc[1:0] != 0.
  2. stall=1: pc, all if_id_* and fetch_count hold.
  3. Otherwise:
     - if_id_instr <= rom_data, if_id_pc <= pc, if_id_pc4 <= pc+4, if_id_valid <= 1.
     - pc <= pc+4; fetch_count <= fetch_count+1.
- Halt edge (RUN with halt=1):
  - The redirect/stall/normal rule above is still applied to pc on this edge.
  - if_id_valid <= 0 regardless; fetch_count does not increment.
- In HALTED:
  - pc holds; if_id_valid = 0; stall and redirect are ignored.
  - On the resume edge, nothing is fetched. The first fetch after resume occurs on the next edge, from the held pc.
- Latency: one cycle from rom_addr = X to if_id_pc = X.
- Arithmetic:
  - pc+4 wraps modulo 2^ADDR_W: 12'hFFC -> 12'h000.
  - fetch_count wraps modulo 2^32.
- rom_addr[1:0] is always 00.

Decomposition:
- Shared package cpu_pkg holds:
  - ADDR_W, DATA_W, NOP_INSTR = 32'h0000_0000.
  - Fetch FSM enum fetch_state_t {RUN, HALTED}.
- Sub-module if_id_reg: the IF/ID register with load/flush/hold controls, reused later for ID/EX-style registers.
- PC logic and FSM stay in instr_fetch_unit.

Test Plan:
- Reset sequence: reset, ROM words 0,4,8 = 0x20080001, 0x20090002, 0x01095020; release, no stall → if_id_pc = 0,4,8 on consecutive edges with matching if_id_instr; fetch_count = 3; if_id_valid = 1 from the first edge.
- Stall: stall=1 for 2 cycles at pc=0x008 → rom_addr stays 0x008 and if_id holds pc 0x004 for 2 cycles; after release, if_id_pc = 0x008.
- Redirect: redirect_valid=1 with stall=1, redirect_pc=0x100 → next edge pc=0x100 and if_id_valid=0; following edge if_id_pc=0x100, valid=1.
- Misaligned redirect: redirect_pc=0x103 → pc=0x100, misalign_err=1, and it stays 1 until reset.
- Wrap-around: pc=0xFFC with no stall → if_id_pc4=0x000 and pc=0x000.
- Halt/resume:
  - halt=1 at pc=0x040 → halted=1, if_id_valid=0, pc=0x044 frozen for 10 cycles, fetch_count unchanged.
  - halt and resume together → remains halted.
  - resume alone → next edge halted=0; the following edge gives if_id_pc=0x044.
  - Assert rst_n=0 mid-halt → all outputs at reset values immediately, without a clock.
